// File: rtl/subway_pkg.sv
// Shared types and constants for the subway move-stream checker.
// Cell/move encodings, error codes and sizing limits used by all checker files.
package subway_pkg;

  localparam int unsigned MAP_LEN  = 64;
  localparam int unsigned MOVE_CNT = 63;
  localparam int unsigned TIMEOUT  = 3000;

  typedef enum logic [1:0] {
    CELL_ROAD  = 2'd0,
    CELL_LOW   = 2'd1,
    CELL_HIGH  = 2'd2,
    CELL_TRAIN = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    MV_FWD   = 2'd0,
    MV_RIGHT = 2'd1,
    MV_LEFT  = 2'd2,
    MV_JUMP  = 2'd3
  } move_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0] ERR_NONE      = 4'd0;
  localparam logic [3:0] ERR_LANE      = 4'd1;
  localparam logic [3:0] ERR_LOW       = 4'd2;
  localparam logic [3:0] ERR_HIGH      = 4'd3;
  localparam logic [3:0] ERR_TRAIN     = 4'd4;
  localparam logic [3:0] ERR_JUMP_HIGH = 4'd5;
  localparam logic [3:0] ERR_TIMEOUT   = 4'd6;
  localparam logic [3:0] ERR_GAP       = 4'd7;
  localparam logic [3:0] ERR_MAP       = 4'd8;

  // A map column is packed as {lane3, lane2, lane1, lane0}, two bits per lane.
  function automatic cell_t cell_at(input logic [7:0] col, input logic [1:0] lane);
    return cell_t'(col[{lane, 1'b0} +: 2]);
  endfunction

endpackage

// File: rtl/subway_move_rule.sv
// Combinational legality check of one move against the current and next map column.
// Reports the first violated rule in priority order together with the resulting lane.
module subway_move_rule
  import subway_pkg::*;
(
  input  logic [1:0] lane,
  input  logic [1:0] move,
  input  logic [1:0] cur_cell,
  input  logic [7:0] target_col,
  output logic       legal,
  output logic [3:0] err_code,
  output logic [1:0] next_lane
);

  move_t move_e;
  cell_t tgt;

  assign move_e = move_t'(move);

  always_comb begin
    err_code  = ERR_NONE;
    next_lane = lane;
    tgt       = CELL_ROAD;
    unique case (move_e)
      MV_FWD: begin
        tgt = cell_at(target_col, lane);
        if (tgt == CELL_LOW)        err_code = ERR_LOW;
        else if (tgt == CELL_TRAIN) err_code = ERR_TRAIN;
      end
      MV_RIGHT, MV_LEFT: begin
        if ((move_e == MV_RIGHT && lane == 2'd3) || (move_e == MV_LEFT && lane == 2'd0)) begin
          err_code = ERR_LANE;
        end else begin
          next_lane = (move_e == MV_RIGHT) ? lane + 2'd1 : lane - 2'd1;
          tgt       = cell_at(target_col, next_lane);
          unique case (tgt)
            CELL_LOW:   err_code = ERR_LOW;
            CELL_HIGH:  err_code = ERR_HIGH;
            CELL_TRAIN: err_code = ERR_TRAIN;
            CELL_ROAD:  err_code = ERR_NONE;
          endcase
        end
      end
      MV_JUMP: begin
        tgt = cell_at(target_col, lane);
        if (tgt == CELL_HIGH)           err_code = ERR_HIGH;
        else if (tgt == CELL_TRAIN)     err_code = ERR_TRAIN;
        else if (cur_cell == CELL_HIGH) err_code = ERR_JUMP_HIGH;
      end
    endcase
    legal = (err_code == ERR_NONE);
  end

endmodule

// File: rtl/subway_checker.sv
// Snoops a 64-column subway map and checks the 63-move stream produced against it.
// Reports pass/first error, offending step and map-to-first-move latency with a done strobe.
module subway_checker
  import subway_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        map_valid,
  input  logic [1:0]  map_init,
  input  logic [1:0]  map_in0,
  input  logic [1:0]  map_in1,
  input  logic [1:0]  map_in2,
  input  logic [1:0]  map_in3,
  input  logic        mv_valid,
  input  logic [1:0]  mv,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_code,
  output logic [5:0]  err_step,
  output logic [11:0] latency
);

  state_t      state, state_next;
  logic [7:0]  map_mem [MAP_LEN];
  logic [7:0]  col_in;
  logic [5:0]  load_cnt;
  logic [5:0]  load_addr;
  logic [5:0]  col;
  logic [5:0]  step;
  logic [1:0]  lane;
  logic [11:0] lat_cnt;

  logic        res_pass;
  logic [3:0]  res_err;
  logic [5:0]  res_step;

  logic        load_start;
  logic        load_wr;
  logic        mv_accept;
  logic        finish;
  logic        fin_pass;
  logic [3:0]  fin_err;
  logic [5:0]  fin_step;

  logic [7:0]  cur_col;
  logic [7:0]  tgt_col;
  logic        rule_legal;
  logic [3:0]  rule_err;
  logic [1:0]  rule_lane;

  assign col_in    = {map_in3, map_in2, map_in1, map_in0};
  assign load_addr = (state == ST_IDLE) ? '0 : load_cnt;
  assign cur_col   = map_mem[col];
  assign tgt_col   = map_mem[col + 6'd1];

  subway_move_rule u_rule (
    .lane       (lane),
    .move       (mv),
    .cur_cell   (cell_at(cur_col, lane)),
    .target_col (tgt_col),
    .legal      (rule_legal),
    .err_code   (rule_err),
    .next_lane  (rule_lane)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // WAIT and CHECK share the evaluator: in WAIT the first mv_valid is move 0,
  // checked from the start position on the same edge that leaves WAIT.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    load_wr    = 1'b0;
    mv_accept  = 1'b0;
    finish     = 1'b0;
    fin_pass   = 1'b0;
    fin_err    = ERR_NONE;
    fin_step   = '0;
    unique case (state)
      ST_IDLE: begin
        if (map_valid) begin
          state_next = ST_LOAD;
          load_start = 1'b1;
          load_wr    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!map_valid) begin
          finish  = 1'b1;
          fin_err = ERR_MAP;
        end else begin
          load_wr = 1'b1;
          if (load_cnt == 6'(MAP_LEN - 1)) state_next = ST_WAIT;
        end
      end
      ST_WAIT, ST_CHECK: begin
        if (map_valid) begin
          finish  = 1'b1;
          fin_err = ERR_MAP;
        end else if (mv_valid) begin
          if (!rule_legal) begin
            finish   = 1'b1;
            fin_err  = rule_err;
            fin_step = step;
          end else begin
            mv_accept = 1'b1;
            if (step == 6'(MOVE_CNT - 1)) begin
              finish   = 1'b1;
              fin_pass = 1'b1;
            end else begin
              state_next = ST_CHECK;
            end
          end
        end else if (state == ST_CHECK) begin
          finish   = 1'b1;
          fin_err  = ERR_GAP;
          fin_step = step;
        end else if (lat_cnt == 12'(TIMEOUT - 1)) begin
          finish  = 1'b1;
          fin_err = ERR_TIMEOUT;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (finish) state_next = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= '0;
      col      <= '0;
      step     <= '0;
      lane     <= '0;
      lat_cnt  <= '0;
      res_pass <= 1'b0;
      res_err  <= '0;
      res_step <= '0;
    end else begin
      if (load_start) begin
        load_cnt <= 6'd1;
        lane     <= map_init;
        col      <= '0;
        step     <= '0;
        lat_cnt  <= '0;
        res_pass <= 1'b0;
        res_err  <= '0;
        res_step <= '0;
      end else if (load_wr) begin
        load_cnt <= load_cnt + 6'd1;
      end
      if (state == ST_WAIT) lat_cnt <= lat_cnt + 12'd1;
      if (mv_accept) begin
        lane <= rule_lane;
        col  <= col + 6'd1;
        step <= step + 6'd1;
      end
      if (finish) begin
        res_pass <= fin_pass;
        res_err  <= fin_err;
        res_step <= fin_step;
      end
    end
  end

  // Map storage is intentionally not reset; every LOAD rewrites it from column 0.
  always_ff @(posedge clk) begin
    if (load_wr && !rst) map_mem[load_addr] <= col_in;
  end

  assign busy     = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_CHECK);
  assign done     = (state == ST_DONE);
  assign pass     = done & res_pass;
  assign err_code = done ? res_err  : '0;
  assign err_step = done ? res_step : '0;
  assign latency  = done ? lat_cnt  : '0;

endmodule

// File: tb/tb_subway_checker.sv
// Scoreboard bench for subway_checker: directed maps/move streams with hand-computed results.
// Stimulus pushes the expected result; a monitor pops and compares on every done strobe.
module tb_subway_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        map_valid = 1'b0;
  logic [1:0]  map_init = '0;
  logic [1:0]  map_in0 = '0, map_in1 = '0, map_in2 = '0, map_in3 = '0;
  logic        mv_valid = 1'b0;
  logic [1:0]  mv = '0;
  logic        busy, done, pass;
  logic [3:0]  err_code;
  logic [5:0]  err_step;
  logic [11:0] latency;

  typedef struct {
    logic        pass;
    logic [3:0]  err;
    logic [5:0]  step;
    logic [11:0] lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  tmap [64][4];
  logic [1:0]  mvs  [63];

  subway_checker dut (
    .clk       (clk),
    .rst       (rst),
    .map_valid (map_valid),
    .map_init  (map_init),
    .map_in0   (map_in0),
    .map_in1   (map_in1),
    .map_in2   (map_in2),
    .map_in3   (map_in3),
    .mv_valid  (mv_valid),
    .mv        (mv),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_code  (err_code),
    .err_step  (err_step),
    .latency   (latency)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done strobe must match the oldest expected result.
  initial begin
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("pass", int'(pass), int'(e.pass));
          check("err_code", int'(err_code), int'(e.err));
          check("err_step", int'(err_step), int'(e.step));
          check("latency", int'(latency), int'(e.lat));
        end
      end else if (prev_done) begin
        check("err_code_after_done", int'(err_code), 0);
        check("latency_after_done", int'(latency), 0);
      end
      prev_done = done;
    end
  end

  task automatic expect_result(input logic p, input logic [3:0] e, input logic [5:0] s,
                               input logic [11:0] l);
    exp_t x;
    x.pass = p; x.err = e; x.step = s; x.lat = l;
    sb.push_back(x);
  endtask

  task automatic clear_map();
    for (int c = 0; c < 64; c++)
      for (int l = 0; l < 4; l++) tmap[c][l] = 2'd0;
    for (int i = 0; i < 63; i++) mvs[i] = 2'd0;
  endtask

  task automatic send_map(input logic [1:0] init, input int ncols);
    for (int c = 0; c < ncols; c++) begin
      map_valid = 1'b1;
      map_init  = init;
      map_in0   = tmap[c][0];
      map_in1   = tmap[c][1];
      map_in2   = tmap[c][2];
      map_in3   = tmap[c][3];
      @(posedge clk); #1;
    end
    map_valid = 1'b0;
    map_in0 = '0; map_in1 = '0; map_in2 = '0; map_in3 = '0;
  endtask

  // First move is sampled lat edges after the edge that took the last column.
  task automatic send_moves(input int lat, input int n);
    repeat (lat - 1) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      mv_valid = 1'b1;
      mv       = mvs[i];
      @(posedge clk); #1;
    end
    mv_valid = 1'b0;
    mv       = '0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err_code"}, int'(err_code), 0);
    check({tag, "_err_step"}, int'(err_step), 0);
    check({tag, "_latency"}, int'(latency), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // All-road map, init 2, 63 forward moves, first move 5 cycles after load.
    clear_map();
    expect_result(1'b1, 4'd0, 6'd0, 12'd5);
    send_map(2'd2, 64);
    send_moves(5, 63);
    wait_drain(100);

    // Low obstacle straight ahead on the first move.
    clear_map();
    tmap[1][0] = 2'd1;
    expect_result(1'b0, 4'd2, 6'd0, 12'd1);
    send_map(2'd0, 64);
    send_moves(1, 1);
    wait_drain(100);

    // Steering right off lane 3.
    clear_map();
    mvs[0] = 2'd1;
    expect_result(1'b0, 4'd1, 6'd0, 12'd3);
    send_map(2'd3, 64);
    send_moves(3, 1);
    wait_drain(100);

    // Jump taken while standing on a high obstacle at column 5.
    clear_map();
    tmap[5][1] = 2'd2;
    mvs[5] = 2'd3;
    expect_result(1'b0, 4'd5, 6'd5, 12'd2);
    send_map(2'd1, 64);
    send_moves(2, 6);
    wait_drain(100);

    // Map strobe drops after 40 columns.
    clear_map();
    expect_result(1'b0, 4'd8, 6'd0, 12'd0);
    send_map(2'd0, 40);
    wait_drain(100);

    // Move stream gap after 10 moves.
    clear_map();
    expect_result(1'b0, 4'd7, 6'd10, 12'd1);
    send_map(2'd1, 64);
    send_moves(1, 10);
    wait_drain(100);

    // Right move into a high obstacle.
    clear_map();
    tmap[1][1] = 2'd2;
    mvs[0] = 2'd1;
    expect_result(1'b0, 4'd3, 6'd0, 12'd2);
    send_map(2'd0, 64);
    send_moves(2, 1);
    wait_drain(100);

    // Jump into a train.
    clear_map();
    tmap[1][1] = 2'd3;
    mvs[0] = 2'd3;
    expect_result(1'b0, 4'd4, 6'd0, 12'd1);
    send_map(2'd1, 64);
    send_moves(1, 1);
    wait_drain(100);

    // Reset pulsed at move 30 aborts without a done; outputs clear next cycle.
    clear_map();
    send_map(2'd2, 64);
    send_moves(1, 30);
    rst      = 1'b1;
    mv_valid = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("abort");
    rst      = 1'b0;
    mv_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_busy_later", int'(busy), 0);

    // Next map after the abort: jump over low, forward onto high, weave, then pass.
    clear_map();
    tmap[1][2] = 2'd1;
    tmap[2][2] = 2'd2;
    tmap[3][1] = 2'd3;
    mvs[0] = 2'd3;
    mvs[1] = 2'd0;
    mvs[2] = 2'd1;
    mvs[3] = 2'd2;
    expect_result(1'b1, 4'd0, 6'd0, 12'd4);
    send_map(2'd2, 64);
    send_moves(4, 63);
    wait_drain(100);

    // No move ever arrives: timeout.
    clear_map();
    expect_result(1'b0, 4'd6, 6'd0, 12'd3000);
    send_map(2'd0, 64);
    wait_drain(3200);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/subway_checker.md
SUBWAY_CHECKER -- requirements
Module: subway_checker

Interface
REQ-001 SHALL provide port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL provide port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL provide port map_valid, input, 1, map column strobe snooped from the subway map bus.
REQ-004 SHALL provide port map_init, input, 2, start lane, valid on the first map_valid cycle.
REQ-005 SHALL provide ports map_in0..map_in3, input, 2 each, cell code for lanes 0..3 of the current column.
REQ-006 SHALL provide ports mv_valid (input, 1) and mv (input, 2), the move stream produced by the subway design.
REQ-007 SHALL provide port busy, output, 1, high in LOAD/WAIT/CHECK.
REQ-008 SHALL provide port done, output, 1, one-cycle result strobe.
REQ-009 SHALL provide port pass, output, 1, valid with done.
REQ-010 SHALL provide port err_code, output, 4, valid with done.
REQ-011 SHALL provide port err_step, output, 6, index 0..62 of the offending move, else 0.
REQ-012 SHALL provide port latency, output, 12, cycles from the last map column to the first mv_valid, valid with done.

Function
REQ-013 SHALL use cell codes 0 road, 1 low obstacle, 2 high obstacle, 3 train; move codes 0 forward, 1 right (lane+1), 2 left (lane-1), 3 jump.
REQ-014 SHALL implement FSM IDLE->LOAD->WAIT->CHECK->DONE->IDLE.
REQ-015 SHALL enter LOAD from IDLE on map_valid, capture map_init and column 0, and store 64 columns x 4 lanes x 2 bits.
REQ-016 SHALL require exactly 64 consecutive map_valid cycles; any earlier deassertion -> err 8, DONE.
REQ-017 SHALL treat map_valid outside IDLE/LOAD as err 8 -> DONE.
REQ-018 SHALL count WAIT cycles in latency; reaching 3000 -> err 6, DONE.
REQ-019 SHALL enter CHECK on the first mv_valid, with position lane=map_init, column=0, step=0.
REQ-020 SHALL check each sampled move against the target cell (column+1) in this priority order.
  - Forward: target 1 -> err 2; target 3 -> err 4.
  - Right/left: lane out of 0..3 -> err 1; target 1 -> err 2; target 2 -> err 3; target 3 -> err 4.
  - Jump: target 2 -> err 3; target 3 -> err 4; current cell 2 -> err 5.
REQ-021 SHALL, on a legal move, update lane and column and increment step.
REQ-022 SHALL record the first error with err_step=step, go to DONE, and ignore all later moves.
REQ-023 SHALL require mv_valid on 63 consecutive cycles; a gap before move 63 -> err 7, err_step=step.
REQ-024 SHALL ignore mv_valid in IDLE and DONE.
REQ-025 SHALL, after a legal 63rd move, enter DONE with pass=1 and err_code=0.
REQ-026 SHALL assert done exactly one cycle after the edge sampling the final or offending event.
REQ-027 SHALL hold pass/err_code/err_step/latency until the next LOAD entry, and drive them 0 when done is low.

Reset
REQ-028 SHALL, with rst high at a clock edge, force IDLE and drive busy, done, pass, err_code, err_step and latency to 0.
REQ-029 SHALL give reset priority over all inputs and abort any mid-operation LOAD/WAIT/CHECK without producing a done.
REQ-030 SHALL not reset the map storage; it is rewritten on every LOAD.

Structure
REQ-031 SHALL take from shared package subway_pkg:
  - Cell and move enums.
  - Error-code constants 0..8.
  - MAP_LEN=64, MOVE_CNT=63, TIMEOUT=3000.
REQ-032 SHALL place move legality in combinational sub-module subway_move_rule.
  - Inputs: lane, move, current cell, target column.
  - Outputs: legal, err_code, next lane.

Verification
REQ-033 SHALL cover an all-road map, init=2, 63 forward moves, with first move 5 cycles after load -> done once, pass=1, err_code=0, latency=5.
REQ-034 SHALL cover column 1 lane 0 = 1, init=0, first move forward -> err_code=2, err_step=0.
REQ-035 SHALL cover init=3, first move right -> err_code=1, err_step=0.
REQ-036 SHALL cover column 5 lane 1 = 2, init=1, moves 0..4 forward, move 5 jump -> err_code=5, err_step=5.
REQ-037 SHALL cover map_valid dropping after 40 columns -> err_code=8; mv_valid gap after 10 moves -> err_code=7, err_step=10.
REQ-038 SHALL cover rst pulsed at move 30 -> all outputs 0 next cycle, no done, and the next map is accepted normally.
